// File: rtl/fp32_mac_seq_ctrl_if.sv
// Handshake bundle between the rx->mac->tx sequencer and its receiver, MAC unit and transmitter.
// master = sequencer side, slave = surrounding datapath.
interface fp32_mac_seq_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             RX_VALID_I;
  logic [95:0]      RX_DATA_I;
  logic             RX_READY_O;
  logic             MAC_START_O;
  logic [31:0]      MAC_A_O;
  logic [31:0]      MAC_B_O;
  logic [31:0]      MAC_C_O;
  logic             MAC_DONE_I;
  logic [31:0]      MAC_RESULT_I;
  logic             TX_START_O;
  logic [7:0]       TX_BYTE_O;
  logic             TX_BUSY_I;
  logic             BUSY_O;
  logic             ERR_TIMEOUT_O;
  logic             DROP_O;
  logic [CNT_W-1:0] RESULT_CNT_O;

  modport master (
    input  RX_VALID_I, RX_DATA_I, MAC_DONE_I, MAC_RESULT_I, TX_BUSY_I,
    output RX_READY_O, MAC_START_O, MAC_A_O, MAC_B_O, MAC_C_O,
           TX_START_O, TX_BYTE_O, BUSY_O, ERR_TIMEOUT_O, DROP_O, RESULT_CNT_O
  );

  modport slave (
    output RX_VALID_I, RX_DATA_I, MAC_DONE_I, MAC_RESULT_I, TX_BUSY_I,
    input  RX_READY_O, MAC_START_O, MAC_A_O, MAC_B_O, MAC_C_O,
           TX_START_O, TX_BYTE_O, BUSY_O, ERR_TIMEOUT_O, DROP_O, RESULT_CNT_O
  );
endinterface

// File: rtl/fp32_mac_seq_ctrl.sv
// Sequencer: captures one A/B/C frame, launches a MAC, sends the 32-bit result as 4 bytes,
// with MAC timeout, completed-result counter and dropped-frame pulse.
module fp32_mac_seq_ctrl #(
  parameter int MAC_TIMEOUT  = 1024,
  parameter int TX_MSB_FIRST = 0,
  parameter int CNT_W        = 16
) (
  input logic                 CLK_I,
  input logic                 RST_I,
  fp32_mac_seq_ctrl_if.master bus
);
  localparam int TW = (MAC_TIMEOUT > 1) ? $clog2(MAC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MAC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, MAC_WAIT, TX_SEND, TX_ACK, TX_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      a_reg, b_reg, c_reg, result_reg;
  logic [1:0]       idx_reg;
  logic [TW-1:0]    tmo_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             armed_reg, rx_valid_prev_reg, err_reg;
  logic             capture, rx_rise, drop, mac_done_ok, tmo_hit, tx_byte_done;
  logic [7:0]       res_bytes [4];

  assign capture      = bus.RX_VALID_I && armed_reg && (state_reg == IDLE);
  assign rx_rise      = bus.RX_VALID_I && !rx_valid_prev_reg;
  assign mac_done_ok  = (state_reg == MAC_WAIT) && bus.MAC_DONE_I;
  assign tmo_hit      = (state_reg == MAC_WAIT) && !bus.MAC_DONE_I && (tmo_reg == TMO_LAST);
  assign tx_byte_done = (state_reg == TX_DONE) && !bus.TX_BUSY_I;
  // An edge in the cycle we fall back to IDLE is not a drop: armed stays set, capture follows.
  assign drop         = rx_rise && (state_reg != IDLE) && (state_next != IDLE);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (capture) state_next = LAUNCH;
      LAUNCH:   state_next = MAC_WAIT;
      MAC_WAIT: if (mac_done_ok) state_next = TX_SEND;
                else if (tmo_hit) state_next = IDLE;
      TX_SEND:  state_next = TX_ACK;
      TX_ACK:   if (bus.TX_BUSY_I) state_next = TX_DONE;
      TX_DONE:  if (tx_byte_done) state_next = (idx_reg == 2'd3) ? IDLE : TX_SEND;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      a_reg             <= '0;
      b_reg             <= '0;
      c_reg             <= '0;
      result_reg        <= '0;
      idx_reg           <= '0;
      tmo_reg           <= '0;
      cnt_reg           <= '0;
      armed_reg         <= 1'b1;
      rx_valid_prev_reg <= 1'b0;
      err_reg           <= 1'b0;
    end else begin
      rx_valid_prev_reg <= bus.RX_VALID_I;
      if (!bus.RX_VALID_I)     armed_reg <= 1'b1;
      else if (capture || drop) armed_reg <= 1'b0;
      if (capture) begin
        a_reg   <= bus.RX_DATA_I[31:0];
        b_reg   <= bus.RX_DATA_I[63:32];
        c_reg   <= bus.RX_DATA_I[95:64];
        err_reg <= 1'b0;
      end
      if (state_reg == LAUNCH)        tmo_reg <= '0;
      else if (state_reg == MAC_WAIT) tmo_reg <= tmo_reg + 1'b1;
      if (tmo_hit) err_reg <= 1'b1;
      if (mac_done_ok) begin
        result_reg <= bus.MAC_RESULT_I;
        idx_reg    <= '0;
      end
      if (tx_byte_done) begin
        if (idx_reg == 2'd3) cnt_reg <= cnt_reg + 1'b1;
        else                 idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  // Byte k of the send order, resolved at elaboration from TX_MSB_FIRST.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_sel
      if (TX_MSB_FIRST != 0) begin : g_msb
        assign res_bytes[gi] = result_reg[31-8*gi -: 8];
      end else begin : g_lsb
        assign res_bytes[gi] = result_reg[8*gi +: 8];
      end
    end
  endgenerate

  always_comb begin
    bus.MAC_START_O = 1'b0;
    bus.TX_START_O  = 1'b0;
    bus.BUSY_O      = 1'b0;
    bus.RX_READY_O  = 1'b0;
    bus.DROP_O      = 1'b0;
    case (state_reg)
      IDLE:    bus.RX_READY_O  = !RST_I;
      LAUNCH:  bus.MAC_START_O = 1'b1;
      TX_SEND: bus.TX_START_O  = 1'b1;
      default: ;
    endcase
    if (state_reg != IDLE) bus.BUSY_O = 1'b1;
    if (drop)              bus.DROP_O = 1'b1;
  end

  assign bus.MAC_A_O       = a_reg;
  assign bus.MAC_B_O       = b_reg;
  assign bus.MAC_C_O       = c_reg;
  assign bus.TX_BYTE_O     = res_bytes[idx_reg];
  assign bus.ERR_TIMEOUT_O = err_reg;
  assign bus.RESULT_CNT_O  = cnt_reg;
endmodule

// File: tb/tb_fp32_mac_seq_ctrl.sv
// Bench for fp32_mac_seq_ctrl: two instances (LSB-first and MSB-first) share stimulus;
// expected bytes/counts come from a result-byte model and a transaction count.
module tb_fp32_mac_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [95:0] rx_data = '0;
  logic        mac_done = 1'b0;
  logic [31:0] mac_result = '0;
  logic        tx_busy = 1'b0;

  int n_pass = 0, n_total = 0;
  int start_cnt = 0, txs_cnt = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  fp32_mac_seq_ctrl_if #(.CNT_W(16)) bus0 ();
  fp32_mac_seq_ctrl_if #(.CNT_W(16)) bus1 ();

  assign bus0.RX_VALID_I = rx_valid;   assign bus1.RX_VALID_I = rx_valid;
  assign bus0.RX_DATA_I = rx_data;     assign bus1.RX_DATA_I = rx_data;
  assign bus0.MAC_DONE_I = mac_done;   assign bus1.MAC_DONE_I = mac_done;
  assign bus0.MAC_RESULT_I = mac_result; assign bus1.MAC_RESULT_I = mac_result;
  assign bus0.TX_BUSY_I = tx_busy;     assign bus1.TX_BUSY_I = tx_busy;

  fp32_mac_seq_ctrl #(.MAC_TIMEOUT(1024), .TX_MSB_FIRST(0), .CNT_W(16)) dut0 (
    .CLK_I(clk), .RST_I(rst), .bus(bus0));
  fp32_mac_seq_ctrl #(.MAC_TIMEOUT(1024), .TX_MSB_FIRST(1), .CNT_W(16)) dut1 (
    .CLK_I(clk), .RST_I(rst), .bus(bus1));

  always @(negedge clk) begin
    if (bus0.MAC_START_O === 1'b1) start_cnt++;
    if (bus0.TX_START_O === 1'b1) txs_cnt++;
  end

  // Byte k of result r in transmit order.
  function automatic logic [7:0] exp_byte(input logic [31:0] r, input int k, input bit msb);
    int sh;
    sh = msb ? 8 * (3 - k) : 8 * k;
    return 8'((r >> sh) & 32'hFF);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send_frame(input logic [95:0] f, input bit hold);
    rx_data = f;
    rx_valid = 1'b1;
    tick();
    chk("launch0", bus0.MAC_START_O, 1);
    chk("launch1", bus1.MAC_START_O, 1);
    chk("operands", {bus0.MAC_C_O, bus0.MAC_B_O, bus0.MAC_A_O}, f);
    chk("err_clear", bus0.ERR_TIMEOUT_O, 0);
    if (!hold) rx_valid = 1'b0;
  endtask

  task automatic mac_respond(input logic [31:0] r, input int delay);
    repeat (delay) tick();
    chk("single_launch", bus0.MAC_START_O, 0);
    mac_done = 1'b1;
    mac_result = r;
    tick();
    mac_done = 1'b0;
    mac_result = $urandom;
    chk("tx_latency0", bus0.TX_START_O, 1);
    chk("tx_latency1", bus1.TX_START_O, 1);
  endtask

  task automatic serve_byte(input logic [31:0] r, input int k, input int bdel, input bit drop);
    chk("byte_lsb", bus0.TX_BYTE_O, exp_byte(r, k, 1'b0));
    chk("byte_msb", bus1.TX_BYTE_O, exp_byte(r, k, 1'b1));
    repeat (bdel) begin
      tick();
      chk("no_restart", bus0.TX_START_O, 0);
    end
    tx_busy = 1'b1;
    tick();
    tick();
    if (drop) begin
      rx_data = {$urandom, $urandom, $urandom};
      rx_valid = 1'b1;
      #1;
      chk("drop_pulse", bus0.DROP_O, 1);
      tick();
      chk("drop_one_cycle", bus0.DROP_O, 0);
    end
    chk("byte_stable", bus0.TX_BYTE_O, exp_byte(r, k, 1'b0));
    tx_busy = 1'b0;
    tick();
  endtask

  task automatic tx_serve(input logic [31:0] r, input int bdel_max, input int drop_k);
    int t0;
    t0 = txs_cnt;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) chk("tx_next", bus0.TX_START_O, 1);
      serve_byte(r, k, $urandom_range(bdel_max, 0), k == drop_k);
    end
    exp_cnt++;
    chk("tx_pulses", txs_cnt - t0, 4);
    chk("result_cnt0", bus0.RESULT_CNT_O, exp_cnt[15:0]);
    chk("result_cnt1", bus1.RESULT_CNT_O, exp_cnt[15:0]);
    chk("ready_after", bus0.RX_READY_O, 1);
    chk("idle_after", bus0.BUSY_O, 0);
  endtask

  task automatic full_frame(input logic [95:0] f, input logic [31:0] r, input int mdel,
                            input int bdel_max, input int drop_k);
    send_frame(f, 1'b0);
    mac_respond(r, mdel);
    tx_serve(r, bdel_max, drop_k);
  endtask

  initial begin
    int s0, t0;
    logic [31:0] r;
    logic [95:0] f;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", bus0.RX_READY_O, 0);
    chk("rst_busy", bus0.BUSY_O, 0);
    chk("rst_start", bus0.MAC_START_O, 0);
    chk("rst_txstart", bus0.TX_START_O, 0);
    chk("rst_err", bus0.ERR_TIMEOUT_O, 0);
    chk("rst_drop", bus0.DROP_O, 0);
    chk("rst_cnt", bus0.RESULT_CNT_O, 0);
    chk("rst_ops", {bus0.MAC_C_O, bus0.MAC_B_O, bus0.MAC_A_O}, 0);
    chk("rst_byte", bus0.TX_BYTE_O, 0);
    rst = 1'b0;
    tick();
    chk("ready_out_of_reset", bus0.RX_READY_O, 1);

    // Single known frame: 1*2+3 = 5.0
    full_frame({32'h40400000, 32'h40000000, 32'h3F800000}, 32'h40A00000, 10, 0, -1);

    // MAC_DONE while idle is ignored
    t0 = txs_cnt;
    mac_done = 1'b1;
    mac_result = 32'hDEADBEEF;
    tick();
    mac_done = 1'b0;
    tick();
    chk("stray_done_busy", bus0.BUSY_O, 0);
    chk("stray_done_tx", txs_cnt - t0, 0);

    // Level valid held for 5000 cycles launches once
    s0 = start_cnt;
    r = $urandom;
    send_frame({$urandom, $urandom, $urandom}, 1'b1);
    mac_respond(r, 5);
    tx_serve(r, 2, -1);
    repeat (4950) tick();
    chk("level_one_launch", start_cnt - s0, 1);
    chk("level_idle", bus0.BUSY_O, 0);
    rx_valid = 1'b0;
    tick();
    full_frame({$urandom, $urandom, $urandom}, $urandom, 7, 1, -1);
    chk("level_second_launch", start_cnt - s0, 2);

    // Timeout: MAC never answers
    t0 = txs_cnt;
    send_frame({$urandom, $urandom, $urandom}, 1'b0);
    repeat (1024) tick();
    chk("tmo_not_yet", bus0.ERR_TIMEOUT_O, 0);
    chk("tmo_still_busy", bus0.BUSY_O, 1);
    tick();
    chk("tmo_flag", bus0.ERR_TIMEOUT_O, 1);
    chk("tmo_idle", bus0.BUSY_O, 0);
    chk("tmo_ready", bus0.RX_READY_O, 1);
    repeat (5) tick();
    chk("tmo_sticky", bus0.ERR_TIMEOUT_O, 1);
    chk("tmo_no_tx", txs_cnt - t0, 0);
    chk("tmo_cnt", bus0.RESULT_CNT_O, exp_cnt[15:0]);
    full_frame({$urandom, $urandom, $urandom}, $urandom, 3, 1, -1);

    // New frame during byte 2: dropped, current result completes, counted once
    s0 = start_cnt;
    full_frame({$urandom, $urandom, $urandom}, $urandom, 4, 1, 2);
    repeat (3) tick();
    chk("drop_no_launch", start_cnt - s0, 1);
    chk("drop_idle", bus0.BUSY_O, 0);
    rx_valid = 1'b0;
    tick();

    // MSB-first instance order and slow busy
    full_frame({$urandom, $urandom, $urandom}, 32'h12345678, 3, 3, -1);

    // Reset in TX_DONE after byte 1
    r = $urandom;
    f = {$urandom, $urandom, $urandom};
    send_frame(f, 1'b0);
    mac_respond(r, 4);
    serve_byte(r, 0, 1, 1'b0);
    chk("rst_mid_byte1", bus0.TX_BYTE_O, exp_byte(r, 1, 1'b0));
    tx_busy = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tx_busy = 1'b0;
    #1;
    chk("rstmid_busy", bus0.BUSY_O, 0);
    chk("rstmid_cnt", bus0.RESULT_CNT_O, 0);
    chk("rstmid_txstart", bus0.TX_START_O, 0);
    chk("rstmid_ops", {bus0.MAC_C_O, bus0.MAC_B_O, bus0.MAC_A_O}, 0);
    chk("rstmid_byte", bus0.TX_BYTE_O, 0);
    chk("rstmid_ready", bus0.RX_READY_O, 0);
    exp_cnt = 0;
    tick();
    rst = 1'b0;
    tick();
    full_frame({$urandom, $urandom, $urandom}, $urandom, 6, 2, -1);

    // Randomized frames
    for (int i = 0; i < 6; i++) begin
      full_frame({$urandom, $urandom, $urandom}, $urandom, $urandom_range(30, 1), 3, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fp32_mac_seq_ctrl.md
Name: fp32_mac_seq_ctrl

Overview:
- Sequencer between the 96-bit fp32 UART receiver, the fp32 MAC unit and the byte-wide UART transmitter in the rx→mac→tx pipeline.
- Accepts one received operand frame (A, B, C), launches one MAC operation (A*B+C) and captures the 32-bit result.
- Serialises the result as 4 bytes to the transmitter, then re-arms for the next frame.
- Also provides timeout protection, a status/result counter and a dropped-frame indication.

Parameters:
- MAC_TIMEOUT, 1024: cycles allowed from MAC_START_O to MAC_DONE_I before abort.
- TX_MSB_FIRST, 0: 0 = result byte [7:0] sent first; 1 = byte [31:24] sent first.
- CNT_W, 16: width of RESULT_CNT_O.

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  asynchronous active-high reset
- RX_VALID_I  in  1  receiver frame valid (level; may stay high until the next start bit)
- RX_DATA_I  in  96  frame, first-received byte at [7:0]; A=[31:0], B=[63:32], C=[95:64]
- RX_READY_O  out  1  controller can accept a frame
- MAC_START_O  out  1  one-cycle launch pulse
- MAC_A_O  out  32  operand A, held from capture until next capture
- MAC_B_O  out  32  operand B
- MAC_C_O  out  32  operand C
- MAC_DONE_I  in  1  one-cycle result-valid pulse
- MAC_RESULT_I  in  32  result, valid with MAC_DONE_I
- TX_START_O  out  1  one-cycle byte launch pulse
- TX_BYTE_O  out  8  byte to send, stable from TX_START_O until TX_BUSY_I falls
- TX_BUSY_I  in  1  transmitter busy
- BUSY_O  out  1  state != IDLE
- ERR_TIMEOUT_O  out  1  sticky MAC timeout flag
- DROP_O  out  1  one-cycle pulse: new frame arrived while busy
- RESULT_CNT_O  out  CNT_W  completed transmissions, wraps

Behaviour:
- Reset: all outputs 0, operand/result registers 0, state IDLE, armed=1, byte index 0.
- RX_READY_O = (state==IDLE).
- Armed flag handles level-valid from the receiver:
  - Cleared on each frame capture.
  - Set in any cycle where RX_VALID_I==0.
  - A frame is captured only when RX_VALID_I & armed & RX_READY_O.
- Rising edge of RX_VALID_I while state!=IDLE: pulse DROP_O for 1 cycle, clear armed. The frame is lost; there is no buffer.
- States:
  - IDLE: on capture, latch A/B/C, clear ERR_TIMEOUT_O → LAUNCH.
  - LAUNCH: MAC_START_O=1 for exactly this cycle, timeout counter=0 → MAC_WAIT.
  - MAC_WAIT: MAC_DONE_I is sampled only here, never in the LAUNCH cycle.
    - On MAC_DONE_I: latch MAC_RESULT_I, byte index=0 → TX_SEND.
    - Else if counter==MAC_TIMEOUT-1: set ERR_TIMEOUT_O, no transmission → IDLE.
    - Else counter+1.
  - TX_SEND: TX_START_O=1 for one cycle, TX_BYTE_O = selected byte → TX_ACK.
    - TX_MSB_FIRST=0: index k selects bits [8k+7:8k].
    - TX_MSB_FIRST=1: index k selects bits [31-8k:24-8k].
  - TX_ACK: wait for TX_BUSY_I==1 → TX_DONE.
  - TX_DONE: wait for TX_BUSY_I==0.
    - If index==3: RESULT_CNT_O+1 (wraps) → IDLE.
    - Else index+1 → TX_SEND.
- Latency:
  - Capture in cycle N → MAC_START_O in cycle N+1.
  - MAC_DONE_I in cycle M → first TX_START_O in cycle M+1.
- MAC_DONE_I outside MAC_WAIT is ignored.
- RX_VALID_I rising in the same cycle the controller returns to IDLE: not captured until the next cycle. armed is still set, so capture occurs one cycle later.
- Reset asserted mid-operation (any state): immediate return to reset values. A partially sent result is abandoned.
- ERR_TIMEOUT_O stays set until the next frame capture or reset.

Test Plan:
- Single frame: A=0x3F800000, B=0x40000000, C=0x40400000; MAC returns 0x40A00000 after 10 cycles → one MAC_START_O, TX bytes 00,00,A0,40 in order; RESULT_CNT_O=1; RX_READY_O high afterwards.
- Level valid: hold RX_VALID_I high for 5000 cycles after one frame → exactly one MAC_START_O. Drop valid for 1 cycle, raise it with a new frame → second launch.
- Timeout: MAC never asserts MAC_DONE_I → ERR_TIMEOUT_O rises exactly 1024 cycles after MAC_START_O; no TX_START_O; back to IDLE. Next frame clears the flag.
- Busy drop: new RX_VALID_I rising edge during byte 2 transmission → DROP_O one-cycle pulse; current result completes; RESULT_CNT_O increments by 1 only.
- TX_MSB_FIRST=1 with result 0x12345678 → bytes 12,34,56,78. TX_BUSY_I delayed 3 cycles after each TX_START_O → no extra start pulses.
- Reset asserted in TX_DONE after byte 1 → all outputs 0 immediately; RESULT_CNT_O=0; the next frame transmits all 4 bytes from byte 0.
